// File: rtl/add_sub_arbiter_if.sv
// ---------------------------------------------------------------------------
// add_sub_arbiter_if
// Bundles the request, response and datapath-side signals of add_sub_arbiter.
//   req/req_sub/req_cin   per-requester request, subtract select, carry-in
//   req_in1/req_in2       packed 16-bit operands, requester i at [16i+15:16i]
//   gnt                   one-hot accept pulse
//   resp_*                result channel (valid/ready) with owner id and flags
//   err_count             saturating count of invalid results
//   alu_*                 connection to the shared add_sub_cla datapath
// Modports: slave = the arbiter, master = requesters/consumer/datapath side.
// ---------------------------------------------------------------------------
interface add_sub_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    req_sub;
  logic [NUM_REQ-1:0]    req_cin;
  logic [16*NUM_REQ-1:0] req_in1;
  logic [16*NUM_REQ-1:0] req_in2;
  logic [NUM_REQ-1:0]    gnt;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [15:0]           resp_out;
  logic                  resp_cout;
  logic                  resp_invalid;
  logic [7:0]            err_count;

  logic                  alu_enable;
  logic                  alu_sub;
  logic                  alu_cin;
  logic [15:0]           alu_in1;
  logic [15:0]           alu_in2;
  logic [15:0]           alu_out;
  logic                  alu_cout;
  logic                  alu_invalid;

  modport slave (
    input  req, req_sub, req_cin, req_in1, req_in2, resp_ready,
           alu_out, alu_cout, alu_invalid,
    output gnt, resp_valid, resp_id, resp_out, resp_cout, resp_invalid,
           err_count, alu_enable, alu_sub, alu_cin, alu_in1, alu_in2
  );

  modport master (
    output req, req_sub, req_cin, req_in1, req_in2, resp_ready,
           alu_out, alu_cout, alu_invalid,
    input  gnt, resp_valid, resp_id, resp_out, resp_cout, resp_invalid,
           err_count, alu_enable, alu_sub, alu_cin, alu_in1, alu_in2
  );
endinterface

// File: rtl/add_sub_arbiter.sv
// ---------------------------------------------------------------------------
// add_sub_arbiter
// Shares one add_sub_cla datapath (16-bit scaled format) between NUM_REQ
// requesters. A round-robin pick in IDLE captures the winner's operands,
// EXEC enables the datapath for LATENCY cycles, RESP holds the captured
// result on a valid/ready channel until accepted. Invalid results are
// counted in a saturating 8-bit counter.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  add_sub_arbiter_if.slave (request, response and datapath signals)
// ---------------------------------------------------------------------------
module add_sub_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  add_sub_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

  state_t          state, state_next;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] id;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] ptr_next;
  logic            win_found;
  logic [2:0]      cnt;
  logic [15:0]     op_in1, op_in2;
  logic            op_sub, op_cin;
  logic [15:0]     in1_arr [NUM_REQ];
  logic [15:0]     in2_arr [NUM_REQ];

  logic [NUM_REQ-1:0] gnt_q;
  logic               resp_valid_q;
  logic [ID_W-1:0]    resp_id_q;
  logic [15:0]        resp_out_q;
  logic               resp_cout_q;
  logic               resp_invalid_q;
  logic [7:0]         err_count_q;

  logic do_grant, do_capture, do_release;

  // Unpack the flat operand buses so the winner can be selected by index.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      in1_arr[i] = bus.req_in1[16*i +: 16];
      in2_arr[i] = bus.req_in2[16*i +: 16];
    end
  end

  // Round-robin pick: scan from ptr downwards in priority. Iterating the
  // offsets from highest to lowest lets the smallest offset overwrite last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    win_found = 1'b0;
    win_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[ID_W'((int'(ptr) + i) % NUM_REQ)]) begin
        win_found = 1'b1;
        win_id    = ID_W'((int'(ptr) + i) % NUM_REQ);
      end
    end
    ptr_next = ID_W'((int'(win_id) + 1) % NUM_REQ);
  end

  // Next-state and control decode.
  always_comb begin
    state_next = state;
    do_grant   = 1'b0;
    do_capture = 1'b0;
    do_release = 1'b0;
    case (state)
      IDLE: if (win_found) begin
        do_grant   = 1'b1;
        state_next = EXEC;
      end
      EXEC: if (cnt == 3'd0) begin
        do_capture = 1'b1;
        state_next = RESP;
      end
      RESP: if (bus.resp_ready) begin
        do_release = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state and datapath registers use non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every register, including the operand and result holding
      // registers, is cleared so all outputs read 0 straight after reset.
      state          <= IDLE;
      ptr            <= '0;
      id             <= '0;
      cnt            <= '0;
      op_in1         <= '0;
      op_in2         <= '0;
      op_sub         <= 1'b0;
      op_cin         <= 1'b0;
      gnt_q          <= '0;
      resp_valid_q   <= 1'b0;
      resp_id_q      <= '0;
      resp_out_q     <= '0;
      resp_cout_q    <= 1'b0;
      resp_invalid_q <= 1'b0;
      err_count_q    <= '0;
    end else begin
      state <= state_next;
      gnt_q <= '0;

      if (do_grant) begin
        op_in1 <= in1_arr[win_id];
        op_in2 <= in2_arr[win_id];
        op_sub <= bus.req_sub[win_id];
        op_cin <= bus.req_cin[win_id];
        id     <= win_id;
        gnt_q  <= NUM_REQ'(1) << win_id;
        ptr    <= ptr_next;
        cnt    <= CNT_INIT;
      end

      if (state == EXEC && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end

      if (do_capture) begin
        resp_out_q     <= bus.alu_out;
        resp_cout_q    <= bus.alu_cout;
        resp_invalid_q <= bus.alu_invalid;
        resp_id_q      <= id;
        resp_valid_q   <= 1'b1;
        if (bus.alu_invalid && err_count_q != 8'hFF) begin
          err_count_q <= err_count_q + 8'd1;
        end
      end

      if (do_release) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_id      = resp_id_q;
  assign bus.resp_out     = resp_out_q;
  assign bus.resp_cout    = resp_cout_q;
  assign bus.resp_invalid = resp_invalid_q;
  assign bus.err_count    = err_count_q;

  // Datapath is fed from the operand registers at all times.
  assign bus.alu_enable = (state == EXEC);
  assign bus.alu_sub    = op_sub;
  assign bus.alu_cin    = op_cin;
  assign bus.alu_in1    = op_in1;
  assign bus.alu_in2    = op_in2;

endmodule

// File: tb/tb_add_sub_arbiter.sv
// ---------------------------------------------------------------------------
// tb_add_sub_arbiter
// Directed bench for add_sub_arbiter: one instance with LATENCY=1 (b1) and
// one with LATENCY=3 (b3). A behavioural stand-in for the add_sub_cla
// datapath adds/subtracts the 13-bit signed mantissas, keeps in1's scale
// and flags mantissa overflow as invalid.
// ---------------------------------------------------------------------------
module tb_add_sub_arbiter;

  logic clk;
  logic rst1, rst3;
  int   passed;
  int   total;

  add_sub_arbiter_if #(.NUM_REQ(4), .ID_W(2)) b1();
  add_sub_arbiter_if #(.NUM_REQ(4), .ID_W(2)) b3();

  add_sub_arbiter #(.NUM_REQ(4), .ID_W(2), .LATENCY(1)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (b1)
  );

  add_sub_arbiter #(.NUM_REQ(4), .ID_W(2), .LATENCY(3)) dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-slot operand tables, packed onto the flat buses.
  logic [15:0] a1 [4];
  logic [15:0] c1 [4];
  logic [15:0] a3 [4];
  logic [15:0] c3 [4];
  assign b1.req_in1 = {a1[3], a1[2], a1[1], a1[0]};
  assign b1.req_in2 = {c1[3], c1[2], c1[1], c1[0]};
  assign b3.req_in1 = {a3[3], a3[2], a3[1], a3[0]};
  assign b3.req_in2 = {c3[3], c3[2], c3[1], c3[0]};

  // Datapath stand-in: {cout, invalid, out}; outputs 0 when not enabled.
  function automatic logic [17:0] dp(input logic [15:0] a, input logic [15:0] b,
                                     input logic sub, input logic cin);
    logic [13:0] ma, mb, m;
    ma = {a[12], a[12:0]};
    mb = {b[12], b[12:0]};
    m  = sub ? (ma - mb - {13'd0, cin}) : (ma + mb + {13'd0, cin});
    return {m[13], m[13] != m[12], a[15:13], m[12:0]};
  endfunction

  assign {b1.alu_cout, b1.alu_invalid, b1.alu_out} =
    b1.alu_enable ? dp(b1.alu_in1, b1.alu_in2, b1.alu_sub, b1.alu_cin) : 18'h0;
  assign {b3.alu_cout, b3.alu_invalid, b3.alu_out} =
    b3.alu_enable ? dp(b3.alu_in1, b3.alu_in2, b3.alu_sub, b3.alu_cin) : 18'h0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until b1 shows a grant, at most 20 cycles; g stays 0 on timeout.
  task automatic wait_gnt1(output logic [3:0] g, output int n);
    g = '0;
    n = 0;
    while (n < 20 && g == '0) begin
      step();
      n++;
      g = b1.gnt;
    end
  endtask

  task automatic test_reset();
    rst1 = 1'b1;
    rst3 = 1'b1;
    step();
    step();
    total++;
    if ({b1.gnt, b1.resp_valid, b1.resp_id, b1.resp_out, b1.resp_cout, b1.resp_invalid,
         b1.err_count, b1.alu_enable, b1.alu_sub, b1.alu_cin, b1.alu_in1, b1.alu_in2} !== '0)
      $display("FAIL reset_b1: outputs=%h want all zero",
        {b1.gnt, b1.resp_valid, b1.resp_id, b1.resp_out, b1.resp_cout, b1.resp_invalid,
         b1.err_count, b1.alu_enable, b1.alu_sub, b1.alu_cin, b1.alu_in1, b1.alu_in2});
    else passed++;
    total++;
    if ({b3.gnt, b3.resp_valid, b3.resp_id, b3.resp_out, b3.resp_cout, b3.resp_invalid,
         b3.err_count, b3.alu_enable, b3.alu_sub, b3.alu_cin, b3.alu_in1, b3.alu_in2} !== '0)
      $display("FAIL reset_b3: outputs=%h want all zero",
        {b3.gnt, b3.resp_valid, b3.resp_id, b3.resp_out, b3.resp_cout, b3.resp_invalid,
         b3.err_count, b3.alu_enable, b3.alu_sub, b3.alu_cin, b3.alu_in1, b3.alu_in2});
    else passed++;
    rst1 = 1'b0;
    rst3 = 1'b0;
  endtask

  task automatic test_single();
    a1[0] = 16'h0005; c1[0] = 16'h0003;
    b1.req_sub = '0; b1.req_cin = '0;
    b1.resp_ready = 1'b1;
    b1.req = 4'b0001;
    step();
    total++;
    if (b1.gnt !== 4'b0001) $display("FAIL single_gnt: got %b want 0001", b1.gnt);
    else passed++;
    total++;
    if ({b1.alu_enable, b1.alu_in1, b1.alu_in2, b1.resp_valid} !== {1'b1, 16'h0005, 16'h0003, 1'b0})
      $display("FAIL single_exec: en=%b in1=%h in2=%h valid=%b want 1 0005 0003 0",
               b1.alu_enable, b1.alu_in1, b1.alu_in2, b1.resp_valid);
    else passed++;
    b1.req = 4'b0000;
    step();
    total++;
    if ({b1.resp_valid, b1.resp_out, b1.resp_id, b1.resp_invalid, b1.gnt} !==
        {1'b1, 16'h0008, 2'd0, 1'b0, 4'b0000})
      $display("FAIL single_resp: valid=%b out=%h id=%0d inv=%b gnt=%b want 1 0008 0 0 0000",
               b1.resp_valid, b1.resp_out, b1.resp_id, b1.resp_invalid, b1.gnt);
    else passed++;
    step();
    total++;
    if ({b1.resp_valid, b1.alu_enable, b1.err_count} !== {1'b0, 1'b0, 8'd0})
      $display("FAIL single_idle: valid=%b en=%b err=%0d want 0 0 0",
               b1.resp_valid, b1.alu_enable, b1.err_count);
    else passed++;
  endtask

  task automatic test_overflow();
    a1[0] = 16'h0FFF; c1[0] = 16'h0001;
    b1.req = 4'b0001;
    step();
    b1.req = 4'b0000;
    step();
    total++;
    if ({b1.resp_valid, b1.resp_out, b1.resp_invalid, b1.err_count} !==
        {1'b1, 16'h1000, 1'b1, 8'd1})
      $display("FAIL overflow: valid=%b out=%h inv=%b err=%0d want 1 1000 1 1",
               b1.resp_valid, b1.resp_out, b1.resp_invalid, b1.err_count);
    else passed++;
    step();
  endtask

  task automatic test_fairness();
    int          exp_order [8];
    logic [3:0]  g, eg;
    int          n;
    exp_order = '{0, 1, 2, 3, 0, 2, 3, 0};
    a1[0] = 16'h0001; c1[0] = 16'h0001;
    a1[1] = 16'h0002; c1[1] = 16'h0001;
    a1[2] = 16'h0003; c1[2] = 16'h0001;
    a1[3] = 16'h0004; c1[3] = 16'h0001;
    b1.req = 4'b1111;
    rst1 = 1'b1;
    step();
    rst1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_gnt1(g, n);
      eg = 4'b0001 << exp_order[i];
      total++;
      if (g !== eg || n !== ((i == 0) ? 1 : 3))
        $display("FAIL fair_grant%0d: gnt=%b after %0d cycles want %b after %0d",
                 i, g, n, eg, (i == 0) ? 1 : 3);
      else passed++;
      if (i == 4) b1.req = 4'b1101;
    end
    b1.req = 4'b0000;
    step();
    step();
    step();
  endtask

  task automatic test_back_to_back();
    logic bad;
    a1[0] = 16'h0100; c1[0] = 16'h0023;
    a1[1] = 16'h0010; c1[1] = 16'h0004;
    b1.req_sub = 4'b0001;
    b1.req_cin = 4'b0010;
    b1.resp_ready = 1'b0;
    b1.req = 4'b0001;
    step();
    total++;
    if (b1.gnt !== 4'b0001) $display("FAIL bp_gnt0: got %b want 0001", b1.gnt);
    else passed++;
    b1.req = 4'b0010;
    step();
    total++;
    if ({b1.resp_valid, b1.resp_out, b1.resp_id} !== {1'b1, 16'h00DD, 2'd0})
      $display("FAIL bp_resp: valid=%b out=%h id=%0d want 1 00dd 0",
               b1.resp_valid, b1.resp_out, b1.resp_id);
    else passed++;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if ({b1.resp_valid, b1.resp_out, b1.resp_id, b1.gnt} !== {1'b1, 16'h00DD, 2'd0, 4'b0000})
        bad = 1'b1;
    end
    total++;
    if (bad !== 1'b0) $display("FAIL bp_hold: disturbed=%b want 0", bad);
    else passed++;
    b1.resp_ready = 1'b1;
    step();
    total++;
    if ({b1.resp_valid, b1.gnt} !== {1'b0, 4'b0000})
      $display("FAIL bp_release: valid=%b gnt=%b want 0 0000", b1.resp_valid, b1.gnt);
    else passed++;
    step();
    total++;
    if (b1.gnt !== 4'b0010) $display("FAIL bp_gnt1: got %b want 0010", b1.gnt);
    else passed++;
    b1.req = 4'b0000;
    step();
    total++;
    if ({b1.resp_valid, b1.resp_out, b1.resp_id, b1.err_count} !== {1'b1, 16'h0015, 2'd1, 8'd0})
      $display("FAIL bp_resp1: valid=%b out=%h id=%0d err=%0d want 1 0015 1 0",
               b1.resp_valid, b1.resp_out, b1.resp_id, b1.err_count);
    else passed++;
    step();
    b1.req_sub = '0;
    b1.req_cin = '0;
  endtask

  task automatic test_saturation();
    logic [3:0] g;
    int         n;
    a1[0] = 16'h0FFF; c1[0] = 16'h0001;
    b1.req = 4'b0001;
    for (int k = 1; k <= 258; k++) begin
      wait_gnt1(g, n);
      step();
      if (k == 128 || k == 255 || k == 258) begin
        total++;
        if (b1.err_count !== ((k == 128) ? 8'd128 : 8'd255) || g !== 4'b0001)
          $display("FAIL sat_%0d: err=%0d gnt=%b want %0d 0001",
                   k, b1.err_count, g, (k == 128) ? 128 : 255);
        else passed++;
      end
    end
    b1.req = 4'b0000;
    step();
    rst1 = 1'b1;
    step();
    rst1 = 1'b0;
    total++;
    if (b1.err_count !== 8'd0) $display("FAIL sat_clear: err=%0d want 0", b1.err_count);
    else passed++;
  endtask

  task automatic test_reset_mid_exec();
    logic bad;
    b3.resp_ready = 1'b1;
    b3.req_sub = 4'b0001;
    b3.req_cin = 4'b0001;
    a3[0] = 16'h0007; c3[0] = 16'h0002;
    a3[1] = 16'h0100; c3[1] = 16'h0001;
    a3[2] = 16'h2040; c3[2] = 16'h0010;
    a3[3] = 16'h0000; c3[3] = 16'h0000;
    b3.req = 4'b0100;
    step();
    total++;
    if ({b3.gnt, b3.alu_enable, b3.alu_in1} !== {4'b0100, 1'b1, 16'h2040})
      $display("FAIL mid_gnt2: gnt=%b en=%b in1=%h want 0100 1 2040",
               b3.gnt, b3.alu_enable, b3.alu_in1);
    else passed++;
    b3.req = 4'b0000;
    step();
    rst3 = 1'b1;
    step();
    rst3 = 1'b0;
    total++;
    if ({b3.gnt, b3.resp_valid, b3.alu_enable, b3.alu_in1, b3.alu_in2, b3.resp_out} !== '0)
      $display("FAIL mid_reset: gnt=%b valid=%b en=%b in1=%h in2=%h out=%h want all zero",
               b3.gnt, b3.resp_valid, b3.alu_enable, b3.alu_in1, b3.alu_in2, b3.resp_out);
    else passed++;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (b3.resp_valid !== 1'b0 || b3.gnt !== 4'b0000) bad = 1'b1;
    end
    total++;
    if (bad !== 1'b0) $display("FAIL mid_quiet: activity=%b want 0", bad);
    else passed++;
    // All requesting: pointer back at 0 means slot 0 wins.
    b3.req = 4'b1111;
    step();
    total++;
    if (b3.gnt !== 4'b0001) $display("FAIL mid_ptr: gnt=%b want 0001", b3.gnt);
    else passed++;
    b3.req = 4'b0000;
    bad = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (b3.resp_valid !== 1'b0 || b3.alu_enable !== 1'b1) bad = 1'b1;
    end
    step();
    total++;
    if (bad !== 1'b0 || {b3.resp_valid, b3.resp_out, b3.resp_id} !== {1'b1, 16'h0004, 2'd0})
      $display("FAIL lat3_resp: early=%b valid=%b out=%h id=%0d want 0 1 0004 0",
               bad, b3.resp_valid, b3.resp_out, b3.resp_id);
    else passed++;
    step();
    b3.req = 4'b0010;
    step();
    total++;
    if (b3.gnt !== 4'b0010) $display("FAIL mid_gnt1: gnt=%b want 0010", b3.gnt);
    else passed++;
    b3.req = 4'b0000;
    step();
    step();
    step();
    total++;
    if ({b3.resp_valid, b3.resp_out, b3.resp_id} !== {1'b1, 16'h0101, 2'd1})
      $display("FAIL mid_resp1: valid=%b out=%h id=%0d want 1 0101 1",
               b3.resp_valid, b3.resp_out, b3.resp_id);
    else passed++;
    step();
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst1 = 1'b1;
    rst3 = 1'b1;
    b1.req = '0; b1.req_sub = '0; b1.req_cin = '0; b1.resp_ready = 1'b1;
    b3.req = '0; b3.req_sub = '0; b3.req_cin = '0; b3.resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a1[i] = '0; c1[i] = '0; a3[i] = '0; c3[i] = '0;
    end
    test_reset();
    test_single();
    test_overflow();
    test_fairness();
    test_back_to_back();
    test_saturation();
    test_reset_mid_exec();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/add_sub_arbiter.md
Name: add_sub_arbiter

Overview:
- Shares one add_sub_cla datapath (16-bit scaled format: [15:13] scale factor, [12:0] signed mantissa) between NUM_REQ ODE-solver requesters.
- Round-robin arbitration.
- Registers the winner's operands and drives the datapath for LATENCY cycles.
- Captures out/cout/invalid and returns them over a valid/ready response channel.
- Counts invalid (overflow) results.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester id (ceil(log2(NUM_REQ))).
- LATENCY, 1, EXEC cycles the datapath is enabled before its outputs are sampled (1..7).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- req  input  NUM_REQ  request bit per requester
- req_sub  input  NUM_REQ  per-requester operation select, 1=subtract
- req_cin  input  NUM_REQ  per-requester carry-in
- req_in1  input  16*NUM_REQ  operand 1, requester i at [16i+15:16i]
- req_in2  input  16*NUM_REQ  operand 2, same packing
- gnt  output  NUM_REQ  one-hot, one-cycle pulse: request accepted, operands captured
- resp_valid  output  1  result available
- resp_ready  input  1  consumer accepts result
- resp_id  output  ID_W  requester that owns the result
- resp_out  output  16  datapath result
- resp_cout  output  1  datapath carry-out
- resp_invalid  output  1  datapath invalid flag
- err_count  output  8  saturating count of invalid results
- alu_enable  output  1  datapath enable
- alu_sub  output  1  datapath sub
- alu_cin  output  1  datapath cin
- alu_in1  output  16  datapath in1
- alu_in2  output  16  datapath in2
- alu_out  input  16  datapath out
- alu_cout  input  1  datapath cout
- alu_invalid  input  1  datapath invalid

Behaviour:
- Reset: one clk, reset is synchronous active-high (rst). All outputs are 0 after reset: gnt, resp_*, err_count, alu_*. Round-robin pointer ptr=0, state=IDLE. Reset mid-operation discards the operation and its response; no gnt or resp_valid follows.
- States: IDLE, EXEC, RESP.
- IDLE, req==0: stay.
- IDLE, req!=0: winner = first set bit scanning ptr, ptr+1, ..., wrapping modulo NUM_REQ. At the edge:
  - op regs <= winner's in1/in2/sub/cin; id <= winner.
  - gnt <= onehot(winner); ptr <= (winner+1) mod NUM_REQ.
  - cnt <= LATENCY-1; state <= EXEC.
- gnt is high exactly one cycle (the first EXEC cycle), otherwise 0.
- A requester deasserts req after seeing gnt. A req still high when IDLE is re-entered is a new request.
- alu_in1/in2/sub/cin are driven from op regs at all times. alu_enable=1 only while state==EXEC.
- EXEC: if cnt!=0, cnt <= cnt-1. If cnt==0, then at the edge:
  - resp_out/resp_cout/resp_invalid <= alu_out/alu_cout/alu_invalid; resp_id <= id.
  - resp_valid <= 1; state <= RESP.
  - if alu_invalid and err_count!=255, err_count <= err_count+1.
- RESP: resp_valid and all resp_* held stable until resp_valid&&resp_ready at an edge. Then resp_valid <= 0 and state <= IDLE. No arbitration and no gnt while in RESP (backpressure stalls all requesters).
- Latency: req sampled at edge E0, resp_valid high after edge E0+LATENCY. Minimum issue interval is LATENCY+2 cycles (IDLE, EXEC×LATENCY, RESP with resp_ready=1).
- err_count saturates at 255 and clears only on rst.
- req bits for indices ≥NUM_REQ do not exist. Operand bits of non-requesting slots are ignored.

Test Plan:
- Single op (LATENCY=1): req=4'b0001, in1_0=16'h0005, in2_0=16'h0003, sub=0, cin=0, resp_ready=1 -> gnt=4'b0001 for one cycle after E0; resp_valid after E0+1 with resp_out=16'h0008, resp_id=0, resp_invalid=0; back to IDLE next cycle.
- Overflow: in1=16'h0FFF, in2=16'h0001, add -> resp_out=16'h1000, resp_invalid=1, err_count=1.
- Fairness: req=4'b1111 held continuously from reset -> grant order 0,1,2,3,0. Then req=4'b1101 after granting 0 -> next grants 2,3,0.
- Backpressure: resp_ready=0 for 5 cycles with req[1]=1 pending -> resp_valid, resp_out, resp_id stable and gnt=0 throughout. gnt[1] pulses the cycle after the IDLE cycle following the handshake.
- Reset mid-EXEC (LATENCY=3): assert rst on the 2nd EXEC cycle -> next cycle all outputs 0, alu_enable=0, ptr=0. No resp_valid appears; subsequent req=4'b0010 is granted normally.
- Saturation: 256 consecutive invalid results -> err_count reaches 255 and stays 255.
